// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed scan controller for a 4-digit
// common-anode seven-segment display. Holds a 16-bit hex value, walks the
// digits at a fixed dwell, and presents one nibble plus active-low anodes.
// New values are staged and applied only at frame boundaries.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seven_segment_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Value,
  input  logic        Load,
  output logic [3:0]  Counter,
  output logic [3:0]  Anode,
  output logic        FrameStart
);

  localparam int             PW        = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]  PRE_TC    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0]  GUARD_V   = PW'(GUARD);
  localparam logic [3:0]     ANODE_RST = (GUARD > 0) ? 4'b1111 : 4'b1110;

  logic [PW-1:0] pre, pre_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   shown, shown_nxt;
  logic [15:0]   pending, pending_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic          tc, fb;
  logic          in_guard, blank;

  // Pick the nibble of v belonging to digit i.
  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0:    nib = v[3:0];
      2'd1:    nib = v[7:4];
      2'd2:    nib = v[11:8];
      default: nib = v[15:12];
    endcase
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Digit i is a leading zero when every nibble from i upward is zero;
  // digit 0 always stays lit so a zero value still shows "0".
  function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] i);
    case (i)
      2'd0:    lead_zero = 1'b0;
      2'd1:    lead_zero = (v[15:4] == 12'h000);
      2'd2:    lead_zero = (v[15:8] == 8'h00);
      default: lead_zero = (v[15:12] == 4'h0);
    endcase
  endfunction
`endif

  // Next-state: prescaler, digit index, and the staged value registers.
  always_comb begin
    tc           = (pre == PRE_TC);
    fb           = tc && (idx == 2'd3);
    pre_nxt      = tc ? '0 : pre + 1'b1;
    idx_nxt      = tc ? idx + 2'd1 : idx;
    shown_nxt    = shown;
    pending_nxt  = pending;
    pend_vld_nxt = pend_vld;
    if (fb) begin
      // A load coinciding with the boundary bypasses the pending stage.
      if (Load)          shown_nxt = Value;
      else if (pend_vld) shown_nxt = pending;
      pend_vld_nxt = 1'b0;
    end else if (Load) begin
      pending_nxt  = Value;
      pend_vld_nxt = 1'b1;
    end
  end

  // GUARD of zero means no blanking window at all.
  if (GUARD == 0) begin : g_no_guard
    assign in_guard = 1'b0;
  end else begin : g_guard
    assign in_guard = (pre_nxt < GUARD_V);
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank = lead_zero(shown_nxt, idx_nxt);
`else
  assign blank = 1'b0;
`endif

  // Stage p0: state registers and outputs, both taken from post-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pre        <= '0;
      idx        <= 2'd0;
      shown      <= 16'h0000;
      pending    <= 16'h0000;
      pend_vld   <= 1'b0;
      Counter    <= 4'h0;
      Anode      <= ANODE_RST;
      FrameStart <= 1'b0;
    end else begin
      pre        <= pre_nxt;
      idx        <= idx_nxt;
      shown      <= shown_nxt;
      pending    <= pending_nxt;
      pend_vld   <= pend_vld_nxt;
      Counter    <= nib(shown_nxt, idx_nxt);
      Anode      <= (in_guard || blank) ? 4'b1111 : ~(4'b0001 << idx_nxt);
      FrameStart <= fb;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with REFRESH_DIV=8, GUARD=2.
// n is the cycle count since reset release; pre = n%8, digit = (n/8)%4.
// exp_shown holds the hand-chosen value that should be on display.
module tb_seven_segment_scanner;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] Value = 16'h0000;
  logic        Load  = 1'b0;
  logic [3:0]  Counter;
  logic [3:0]  Anode;
  logic        FrameStart;

  int          asserts = 0;
  int          fails   = 0;
  int          n       = 0;
  logic [15:0] exp_shown = 16'h0000;

  seven_segment_scanner #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .Clock(Clock), .Reset(Reset), .Value(Value), .Load(Load),
    .Counter(Counter), .Anode(Anode), .FrameStart(FrameStart)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    asserts++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s n=%0d observed %h expected %h", tag, n, obs, exp);
    end
  endtask

  function automatic logic [3:0] digit_of(input logic [15:0] v, input int d);
    logic [15:0] s;
    s = v >> (4 * d);
    return s[3:0];
  endfunction

  function automatic logic [3:0] exp_anode(input int cyc, input logic [15:0] v);
    int d;
    logic [3:0] a;
    d = (cyc / 8) % 4;
    a = ~(4'b0001 << d);
    if ((cyc % 8) < 2) a = 4'b1111;
`ifdef LEADING_ZERO_BLANK_EN
    if (d >= 1 && (v >> (4 * d)) == 16'h0000) a = 4'b1111;
`endif
    return a;
  endfunction

  // One clock edge, then check all outputs 1 time unit later.
  task automatic tick();
    @(posedge Clock);
    #1;
    n = Reset ? 0 : n + 1;
    chk("counter", {12'h0, Counter}, {12'h0, digit_of(exp_shown, (n / 8) % 4)});
    chk("anode", {12'h0, Anode}, {12'h0, exp_anode(n, exp_shown)});
    chk("framestart", {15'h0, FrameStart}, {15'h0, (n > 0) && (n % 32 == 0)});
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic load_tick(input logic [15:0] v);
    Load  = 1'b1;
    Value = v;
    tick();
    Load  = 1'b0;
    Value = 16'hDEAD;
  endtask

  task automatic reset_tick();
    Reset = 1'b1;
    exp_shown = 16'h0000;
    tick();
    Reset = 1'b0;
  endtask

  initial begin
    // Reset state and idle scan: zero shown, framestart at cycle 32.
    Reset = 1'b1;
    exp_shown = 16'h0000;
    tick();
    Reset = 1'b0;
    run_to(40);

    // Load 0xA5C3 at cycle 5; appears only after the first boundary.
    reset_tick();
    run_to(5);
    load_tick(16'hA5C3);
    run_to(31);
    exp_shown = 16'hA5C3;
    tick();
    chk("first_digit_is_3", {12'h0, Counter}, 16'h0003);
    chk("fs_with_first_3", {15'h0, FrameStart}, 16'h0001);
    run_to(64);

    // Two loads in one frame: last wins, 0x1111 never shown.
    run_to(66);
    load_tick(16'h1111);
    run_to(80);
    load_tick(16'h2222);
    run_to(95);
    exp_shown = 16'h2222;
    run_to(159);

    // Load exactly on the boundary cycle (n%32==31): bypass path.
    exp_shown = 16'h00F0;
    load_tick(16'h00F0);
    chk("bypass_counter0", {12'h0, Counter}, 16'h0000);
    run_to(168);
    chk("bypass_digit1_F", {12'h0, Counter}, 16'h000F);
    run_to(192);

    // 0x0042: without blanking all four digits light.
    run_to(195);
    load_tick(16'h0042);
    run_to(223);
    exp_shown = 16'h0042;
    run_to(256);

    // Reset in digit 2 dwell with a pending load: pending is dropped.
    run_to(260);
    load_tick(16'h7777);
    run_to(276);
    reset_tick();
    chk("reset_counter", {12'h0, Counter}, 16'h0000);
    chk("reset_anode", {12'h0, Anode}, 16'h000F);
    run_to(72);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
